rx_module: RTL and testbench



---
 rtl/rx_pkg.sv | 13 +
 rtl/rx_bps_module.sv | 46 ++++
 rtl/rx_module.sv | 145 ++++++++++++++
 tb/tb_rx_module.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the UART 8N1 receive path.
package rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_bps_module.sv
// Receive baud generator: counts while a frame is active and strobes at the
// half-bit point (start bit) or at every full bit period (data/stop bits).
module rx_bps_module #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic count_sig,
    input  logic half_sel,
    output logic bps_clk
);

    localparam int BPS_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int CNT_W    = $clog2(BPS_CNT);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_cnt;

    // The counter wraps to zero on every strobe, so each sample point starts
    // a fresh period without the FSM having to clear it explicitly.
    always_comb begin
        last_cnt = half_sel ? HALF_LAST : FULL_LAST;
        bps_clk  = count_sig && (cnt_q == last_cnt);
        if (!count_sig || bps_clk) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_module.sv
// UART 8N1 receiver: synchronises the line, detects the start edge, samples
// mid-bit and reports each byte with a done or framing-error strobe.
module rx_module
    import rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en_sig,
    input  logic                 rx_pin_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_sig,
    output logic                 rx_err_sig,
    output logic                 rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam int BIDX_W  = $clog2(DATA_BITS);
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE = BIDX_W'(1);

    generate
        if (BPS_CNT < 4) begin : g_bad_baud
            $error("rx_module: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    rx_state_t state_q, state_d;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 hist_q, hist_d;
    logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic fall_edge;
    logic count_sig;
    logic half_sel;
    logic bps_clk;

    assign fall_edge = hist_q && !sync2_q;

    rx_bps_module #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_bps (
        .clk       (clk),
        .rst       (rst),
        .count_sig (count_sig),
        .half_sel  (half_sel),
        .bps_clk   (bps_clk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping the enable aborts any frame in flight on the next clock.
    always_comb begin
        state_d = state_q;
        if (!rx_en_sig) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (fall_edge) state_d = START;
                START: if (bps_clk)   state_d = sync2_q ? IDLE : DATA;
                DATA:  if (bps_clk && (bit_idx_q == LAST_BIT)) state_d = STOP;
                STOP:  if (bps_clk)   state_d = IDLE;
                default:              state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy   = (state_q != IDLE);
        count_sig = (state_q != IDLE);
        half_sel  = (state_q == START);
    end

    always_comb begin
        sync1_d   = rx_pin_in;
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (rx_en_sig && bps_clk) begin
            case (state_q)
                START: bit_idx_d = '0;
                DATA: begin
                    shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BIDX_ONE;
                end
                STOP: begin
                    if (sync2_q) begin
                        rx_data_d = shift_q;
                        done_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchroniser and history reset high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            hist_q    <= 1'b1;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_done_sig = done_q;
    assign rx_err_sig  = err_q;

endmodule

// File: tb/tb_rx_module.sv
// Directed bench for rx_module at 16 clocks per bit (CLK_FREQ=160, BAUD=10).
module tb_rx_module;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en_sig;
    logic       rx_pin_in;
    logic [7:0] rx_data;
    logic       rx_done_sig;
    logic       rx_err_sig;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         edge_cyc = 0;
    int         done_total = 0;
    int         err_total = 0;
    int         busy_total = 0;
    int         both_total = 0;
    int         done_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;

    rx_module #(
        .CLK_FREQ (160),
        .BAUD     (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en_sig   (rx_en_sig),
        .rx_pin_in   (rx_pin_in),
        .rx_data     (rx_data),
        .rx_done_sig (rx_done_sig),
        .rx_err_sig  (rx_err_sig),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done_sig) begin
            done_total <= done_total + 1;
            prev_data  <= last_data;
            last_data  <= rx_data;
            done_cyc   <= cyc;
        end
        if (rx_err_sig) err_total <= err_total + 1;
        if (rx_busy) busy_total <= busy_total + 1;
        if (rx_done_sig && rx_err_sig) both_total <= both_total + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive_cycles(input logic b, input int n);
        rx_pin_in = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [9:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) drive_cycles(f[i], 16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        edge_cyc = cyc;
        drive_bits({stop, d, 1'b0}, 0, 9);
    endtask

    int         d0, e0, b0, lat;
    logic [9:0] f;

    initial begin
        rst       = 1'b1;
        rx_en_sig = 1'b1;
        rx_pin_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_data", 32'(rx_data), 32'h00);
        check_val("rst_done", 32'(rx_done_sig), 32'h0);
        check_val("rst_err", 32'(rx_err_sig), 32'h0);
        check_val("rst_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        drive_cycles(1'b1, 20);
        check_val("post_rst_busy", 32'(busy_total), 32'd0);

        // Single frame 0xA5
        d0 = done_total; e0 = err_total;
        send_frame(8'hA5, 1'b1);
        drive_cycles(1'b1, 20);
        lat = done_cyc - edge_cyc;
        $display("frame A5: done=%0d data=%02h latency=%0d", done_total - d0, rx_data, lat);
        check_val("a5_done_cnt", 32'(done_total - d0), 32'd1);
        check_val("a5_data", 32'(last_data), 32'hA5);
        check_val("a5_rx_data", 32'(rx_data), 32'hA5);
        check_val("a5_err", 32'(err_total - e0), 32'd0);
        check_val("a5_latency_in_range", 32'(lat >= 154 && lat <= 156), 32'd1);

        // Back-to-back 0x00 then 0xFF
        d0 = done_total; e0 = err_total;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_cycles(1'b1, 20);
        $display("frames 00,FF: done=%0d data=%02h,%02h", done_total - d0, prev_data, last_data);
        check_val("b2b_done_cnt", 32'(done_total - d0), 32'd2);
        check_val("b2b_first", 32'(prev_data), 32'h00);
        check_val("b2b_second", 32'(last_data), 32'hFF);
        check_val("b2b_err", 32'(err_total - e0), 32'd0);

        // Three-clock glitch
        d0 = done_total; e0 = err_total; b0 = busy_total;
        drive_cycles(1'b0, 3);
        drive_cycles(1'b1, 9);
        $display("glitch: busy cycles=%0d busy_now=%0b", busy_total - b0, rx_busy);
        check_val("glitch_busy_seen", 32'(busy_total - b0 > 0), 32'd1);
        check_val("glitch_busy_low", 32'(rx_busy), 32'd0);
        drive_cycles(1'b1, 10);
        check_val("glitch_done", 32'(done_total - d0), 32'd0);
        check_val("glitch_err", 32'(err_total - e0), 32'd0);

        // Framing error: 0x3C with stop bit 0, line held low 40 clocks
        d0 = done_total; e0 = err_total;
        send_frame(8'h3C, 1'b0);
        drive_cycles(1'b0, 24);
        check_val("ferr_no_retrigger", 32'(rx_busy), 32'd0);
        drive_cycles(1'b1, 20);
        $display("frame 3C/stop0: err=%0d done=%0d data=%02h", err_total - e0, done_total - d0, rx_data);
        check_val("ferr_err_cnt", 32'(err_total - e0), 32'd1);
        check_val("ferr_done_cnt", 32'(done_total - d0), 32'd0);
        check_val("ferr_data_kept", 32'(rx_data), 32'hFF);
        send_frame(8'h81, 1'b1);
        drive_cycles(1'b1, 20);
        $display("frame 81: data=%02h", rx_data);
        check_val("ferr_next_done", 32'(done_total - d0), 32'd1);
        check_val("ferr_next_data", 32'(rx_data), 32'h81);

        // Abort: drop enable mid bit 4 of 0x5A
        d0 = done_total; e0 = err_total;
        f = {1'b1, 8'h5A, 1'b0};
        drive_bits(f, 0, 4);
        drive_cycles(f[5], 8);
        check_val("abort_busy_before", 32'(rx_busy), 32'd1);
        rx_en_sig = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_busy_after", 32'(rx_busy), 32'd0);
        drive_cycles(f[5], 7);
        drive_bits(f, 6, 9);
        drive_cycles(1'b1, 16);
        rx_en_sig = 1'b1;
        drive_cycles(1'b1, 16);
        $display("abort 5A: done=%0d err=%0d data=%02h", done_total - d0, err_total - e0, rx_data);
        check_val("abort_done", 32'(done_total - d0), 32'd0);
        check_val("abort_err", 32'(err_total - e0), 32'd0);
        check_val("abort_data", 32'(rx_data), 32'h81);

        // Reset during bit 2 of 0xFC (rest of frame is all ones, so no new edge)
        d0 = done_total;
        f = {1'b1, 8'hFC, 1'b0};
        drive_bits(f, 0, 2);
        drive_cycles(f[3], 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_data", 32'(rx_data), 32'h00);
        check_val("mid_rst_busy", 32'(rx_busy), 32'd0);
        check_val("mid_rst_done", 32'(rx_done_sig), 32'd0);
        check_val("mid_rst_err", 32'(rx_err_sig), 32'd0);
        rst = 1'b0;
        drive_cycles(f[3], 7);
        drive_bits(f, 4, 9);
        drive_cycles(1'b1, 16);
        check_val("mid_rst_no_done", 32'(done_total - d0), 32'd0);
        send_frame(8'hC3, 1'b1);
        drive_cycles(1'b1, 20);
        $display("frame C3 after reset: data=%02h", rx_data);
        check_val("c3_done", 32'(done_total - d0), 32'd1);
        check_val("c3_data", 32'(rx_data), 32'hC3);

        // Enable gating with 0x77
        d0 = done_total; e0 = err_total; b0 = busy_total;
        rx_en_sig = 1'b0;
        send_frame(8'h77, 1'b1);
        drive_cycles(1'b1, 16);
        f = {1'b1, 8'h77, 1'b0};
        drive_bits(f, 0, 7);
        drive_cycles(f[8], 8);
        rx_en_sig = 1'b1;
        drive_cycles(f[8], 8);
        drive_bits(f, 9, 9);
        drive_cycles(1'b1, 16);
        $display("gated 77: busy cycles=%0d done=%0d", busy_total - b0, done_total - d0);
        check_val("gate_busy", 32'(busy_total - b0), 32'd0);
        check_val("gate_done", 32'(done_total - d0), 32'd0);
        check_val("gate_err", 32'(err_total - e0), 32'd0);
        send_frame(8'h77, 1'b1);
        drive_cycles(1'b1, 20);
        $display("frame 77 enabled: data=%02h", rx_data);
        check_val("gate_next_done", 32'(done_total - d0), 32'd1);
        check_val("gate_next_data", 32'(rx_data), 32'h77);

        check_val("done_err_exclusive", 32'(both_total), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
